// File: rtl/abl17_alu_fault_campaign_pkg.sv
// Shared definitions for the ALU fault-injection campaign controller.
// Holds the ALU opcode constants, fault-mode encodings, FSM state type, the
// LFSR tap mask and small helpers that map an LFSR value onto ALU stimulus.
package abl17_alu_fault_campaign_pkg;

   // ALU opcodes driven onto ctrl_ALUopcode
   localparam logic [4:0] OP_ADD = 5'd0;
   localparam logic [4:0] OP_SUB = 5'd1;
   localparam logic [4:0] OP_SLL = 5'd4;
   localparam logic [4:0] OP_SRA = 5'd5;

   // Fault-mode encodings (fault_mode input and effective per-vector mode)
   localparam logic [1:0] MODE_FLIP1 = 2'd0;
   localparam logic [1:0] MODE_FLIP2 = 2'd1;
   localparam logic [1:0] MODE_SHIFT = 2'd2;
   localparam logic [1:0] MODE_RR    = 2'd3;

   // Galois LFSR feedback mask, applied when the bit shifted out is 1
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   typedef enum logic [1:0] {
      StIdle,
      StClean,
      StFault,
      StDone
   } state_t;

   function automatic logic [31:0] lfsr_step(input logic [31:0] value);
      return value[0] ? ((value >> 1) ^ LFSR_TAPS) : (value >> 1);
   endfunction

   function automatic logic [31:0] map_operand_b(input logic [31:0] value);
      return {value[15:0], value[31:16]} ^ 32'h5A5A_5A5A;
   endfunction

   // Adder modes pick ADD/SUB, the shift mode picks SLL/SRA; sel is lfsr[5]
   function automatic logic [4:0] map_opcode(input logic [1:0] eff_mode, input logic sel);
      if (eff_mode == MODE_SHIFT) begin
         return sel ? OP_SRA : OP_SLL;
      end
      return sel ? OP_SUB : OP_ADD;
   endfunction

endpackage

// File: rtl/abl17_lfsr32.sv
// 32-bit right-shifting Galois LFSR used as the campaign's vector source.
// Ports:
//   clock, reset_n  - rising-edge clock, synchronous active-low reset (loads SEED)
//   load_seed       - reload SEED (has priority over advance)
//   advance         - step the LFSR once
//   state           - current LFSR value
//   state_next      - value the LFSR takes on the next advance
module abl17_lfsr32
   import abl17_alu_fault_campaign_pkg::*;
#(
   parameter logic [31:0] SEED = 32'h1ACE_B00C
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        load_seed,
   input  logic        advance,
   output logic [31:0] state,
   output logic [31:0] state_next
);

   logic [31:0] lfsr_q;

   always_comb begin
      state_next = lfsr_step(lfsr_q);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         lfsr_q <= SEED;
      end else if (load_seed) begin
         lfsr_q <= SEED;
      end else if (advance) begin
         lfsr_q <= state_next;
      end
   end

   assign state = lfsr_q;

endmodule

// File: rtl/abl17_alu_fault_campaign.sv
// Fault-injection campaign controller for the faulted ALU.
// For every pseudo-random vector it runs a clean phase (no flips) and a faulted
// phase (one flip asserted), samples the checker flags on the last cycle of
// each phase and keeps saturating campaign counters.
// Ports:
//   clock, reset_n          - rising-edge clock, synchronous active-low reset
//   start                   - start pulse, accepted in IDLE/DONE only
//   fault_mode, num_vectors - campaign setup, latched at start
//   *_has_error             - ALU checker flags
//   data_*, ctrl_*          - registered ALU stimulus and fault controls
//   busy, done              - campaign status
//   *_count                 - campaign result counters
module abl17_alu_fault_campaign
   import abl17_alu_fault_campaign_pkg::*;
#(
   parameter int unsigned CNT_W  = 16,
   parameter logic [31:0] SEED   = 32'h1ACE_B00C,
   parameter int unsigned SETTLE = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       fault_mode,
   input  logic [CNT_W-1:0] num_vectors,
   input  logic             adder_has_error,
   input  logic             sra_has_error,
   input  logic             sll_has_error,
   output logic [31:0]      data_operandA,
   output logic [31:0]      data_operandB,
   output logic [4:0]       ctrl_ALUopcode,
   output logic [4:0]       ctrl_shiftamt,
   output logic             ctrl_adder_flip1,
   output logic             ctrl_adder_flip2,
   output logic             ctrl_shift_flip,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] injected_count,
   output logic [CNT_W-1:0] detected_count,
   output logic [CNT_W-1:0] escaped_count,
   output logic [CNT_W-1:0] false_alarm_count
);

   localparam logic [3:0] PHASE_LAST = 4'(SETTLE - 1);

   state_t           state_q, state_d;
   logic [3:0]       phase_q;
   logic [1:0]       mode_q;
   logic [1:0]       eff_q;
   logic [CNT_W-1:0] rem_q;    // vectors still to run after the current one

   logic [31:0] lfsr_value, lfsr_next;
   logic        lfsr_load, lfsr_advance;
   logic        phase_last, start_ok, more_vectors;
   logic [1:0]  eff_start, eff_next;
   logic        any_flag, relevant_flag;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      return (&value) ? value : value + 1'b1;
   endfunction

   abl17_lfsr32 #(
      .SEED(SEED)
   ) u_lfsr (
      .clock      (clock),
      .reset_n    (reset_n),
      .load_seed  (lfsr_load),
      .advance    (lfsr_advance),
      .state      (lfsr_value),
      .state_next (lfsr_next)
   );

   always_comb begin
      phase_last    = (phase_q == PHASE_LAST);
      start_ok      = start && (state_q == StIdle || state_q == StDone);
      more_vectors  = (rem_q != '0);
      eff_start     = (fault_mode == MODE_RR) ? MODE_FLIP1 : fault_mode;
      if (mode_q == MODE_RR) begin
         eff_next = (eff_q == MODE_SHIFT) ? MODE_FLIP1 : eff_q + 2'd1;
      end else begin
         eff_next = mode_q;
      end
      any_flag = adder_has_error | sra_has_error | sll_has_error;
      if (eff_q != MODE_SHIFT) begin
         relevant_flag = adder_has_error;
      end else begin
         relevant_flag = (ctrl_ALUopcode == OP_SRA) ? sra_has_error : sll_has_error;
      end
      // Every campaign starts from SEED so runs are reproducible
      lfsr_load    = start_ok;
      lfsr_advance = (state_q == StFault) && phase_last && more_vectors;
   end

   // FSM: state register
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = (num_vectors == '0) ? StDone : StClean;
            end
         end
         StClean: begin
            if (phase_last) begin
               state_d = StFault;
            end
         end
         StFault: begin
            if (phase_last) begin
               state_d = more_vectors ? StClean : StDone;
            end
         end
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy = (state_q == StClean) || (state_q == StFault);
      done = (state_q == StDone);
   end

   // Stimulus, phase timing and counters
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         phase_q           <= '0;
         mode_q            <= '0;
         eff_q             <= '0;
         rem_q             <= '0;
         data_operandA     <= '0;
         data_operandB     <= '0;
         ctrl_ALUopcode    <= '0;
         ctrl_shiftamt     <= '0;
         ctrl_adder_flip1  <= 1'b0;
         ctrl_adder_flip2  <= 1'b0;
         ctrl_shift_flip   <= 1'b0;
         injected_count    <= '0;
         detected_count    <= '0;
         escaped_count     <= '0;
         false_alarm_count <= '0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start_ok) begin
                  mode_q            <= fault_mode;
                  phase_q           <= '0;
                  injected_count    <= '0;
                  detected_count    <= '0;
                  escaped_count     <= '0;
                  false_alarm_count <= '0;
                  if (num_vectors != '0) begin
                     rem_q          <= num_vectors - 1'b1;
                     eff_q          <= eff_start;
                     data_operandA  <= SEED;
                     data_operandB  <= map_operand_b(SEED);
                     ctrl_shiftamt  <= SEED[4:0];
                     ctrl_ALUopcode <= map_opcode(eff_start, SEED[5]);
                  end
               end
            end
            StClean: begin
               if (phase_last) begin
                  phase_q          <= '0;
                  ctrl_adder_flip1 <= (eff_q == MODE_FLIP1);
                  ctrl_adder_flip2 <= (eff_q == MODE_FLIP2);
                  ctrl_shift_flip  <= (eff_q == MODE_SHIFT);
                  if (any_flag) begin
                     false_alarm_count <= sat_inc(false_alarm_count);
                  end
               end else begin
                  phase_q <= phase_q + 4'd1;
               end
            end
            StFault: begin
               if (phase_last) begin
                  phase_q          <= '0;
                  ctrl_adder_flip1 <= 1'b0;
                  ctrl_adder_flip2 <= 1'b0;
                  ctrl_shift_flip  <= 1'b0;
                  injected_count   <= sat_inc(injected_count);
                  if (relevant_flag) begin
                     detected_count <= sat_inc(detected_count);
                  end else begin
                     escaped_count <= sat_inc(escaped_count);
                  end
                  if (more_vectors) begin
                     rem_q          <= rem_q - 1'b1;
                     eff_q          <= eff_next;
                     data_operandA  <= lfsr_next;
                     data_operandB  <= map_operand_b(lfsr_next);
                     ctrl_shiftamt  <= lfsr_next[4:0];
                     ctrl_ALUopcode <= map_opcode(eff_next, lfsr_next[5]);
                  end
               end else begin
                  phase_q <= phase_q + 4'd1;
               end
            end
         endcase
      end
   end

   // LFSR state is consumed through lfsr_next; keep the current value observable
   logic unused_lfsr;
   assign unused_lfsr = ^lfsr_value;

endmodule

// File: doc/abl17_alu_fault_campaign.md
Name: abl17_alu_fault_campaign

Overview:
- Fault-injection campaign controller: the driving end of the faulted ALU's fault-control and checker-flag interface.
- Generates pseudo-random operand vectors and drives the ALU operands, opcode and shift amount.
- For each vector, runs a clean phase and a faulted phase, asserting the selected fault-flip control only in the faulted phase.
- Samples the adder/SRA/SLL checker error flags and accumulates injected, detected, escaped and false-alarm counts for the campaign.

Parameters:
- CNT_W, 16, width of vector count and all result counters.
- SEED, 32'h1ACE_B00C, LFSR reset/start value; must be nonzero.
- SETTLE, 1, cycles each phase is held; flags are sampled on the last cycle of the phase (range 1..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  start pulse; accepted only in IDLE or DONE.
- fault_mode  in  2  0=adder flip1, 1=adder flip2, 2=shift flip, 3=round-robin 0,1,2 per vector; latched at start.
- num_vectors  in  CNT_W  vectors in the campaign; latched at start.
- adder_has_error  in  1  adder checker flag from the ALU.
- sra_has_error  in  1  SRA checker flag from the ALU.
- sll_has_error  in  1  SLL checker flag from the ALU.
- data_operandA  out  32  ALU operand A (registered).
- data_operandB  out  32  ALU operand B (registered).
- ctrl_ALUopcode  out  5  ALU opcode (registered).
- ctrl_shiftamt  out  5  ALU shift amount (registered).
- ctrl_adder_flip1  out  1  adder fault control 1 (registered).
- ctrl_adder_flip2  out  1  adder fault control 2 (registered).
- ctrl_shift_flip  out  1  shift fault control (registered).
- busy  out  1  campaign in progress.
- done  out  1  campaign complete; level signal.
- injected_count  out  CNT_W  faulted phases executed.
- detected_count  out  CNT_W  faulted phases in which the relevant flag was 1.
- escaped_count  out  CNT_W  faulted phases in which the relevant flag was 0.
- false_alarm_count  out  CNT_W  clean phases in which any flag was 1.

Behaviour:
- Reset (reset_n=0 at an edge):
  - State=IDLE; LFSR=SEED.
  - All data/ctrl outputs, counters, busy and done = 0.
  - Overrides everything, including mid-campaign: the next cycle is IDLE with all flips 0.
- States: IDLE, CLEAN, FAULT, DONE.
- IDLE/DONE with start=1:
  - Latch fault_mode and num_vectors; clear all counters; done=0.
  - num_vectors==0: go to DONE next cycle, done=1, counters remain 0, ALU outputs unchanged.
  - Otherwise: load vector 0 and go to CLEAN with busy=1. The first vector is visible the cycle after start is accepted.
- start while busy: ignored.
- Vector generation, per vector:
  - data_operandA = lfsr.
  - data_operandB = {lfsr[15:0], lfsr[31:16]} XOR 32'h5A5A_5A5A.
  - ctrl_shiftamt = lfsr[4:0].
  - Opcode: adder modes use ADD (0) when lfsr[5]=0, else SUB (1). Shift mode uses SLL (4) when lfsr[5]=0, else SRA (5).
  - Effective mode: in round-robin mode = vector_index mod 3; otherwise the latched fault_mode.
  - LFSR: 32-bit Galois, taps 32'h8020_0003, shifted right, advanced exactly once when moving from FAULT to the next CLEAN.
- CLEAN: all flips 0; held SETTLE cycles. On the last cycle, if any of the three flags is 1, false_alarm_count+1. Then go to FAULT.
- FAULT:
  - Operands, opcode and shift amount unchanged from CLEAN; only the flip for the effective mode is set (mode 0: flip1, mode 1: flip2, mode 2: shift_flip).
  - Held SETTLE cycles. On the last cycle, injected_count+1 and sample the relevant flag:
    - adder modes: adder_has_error;
    - shift mode with SLL: sll_has_error;
    - shift mode with SRA: sra_has_error.
  - Relevant flag 1: detected_count+1; relevant flag 0: escaped_count+1.
  - If more vectors remain, go to CLEAN with the next vector; else go to DONE.
  - On the transition out of FAULT, all flips return to 0.
- DONE: busy=0, done=1; outputs and counters hold until a new start or reset.
- Invariant at DONE: injected_count = detected_count + escaped_count = num_vectors.
- Counters saturate at all-ones and never wrap.
- Cycles from start acceptance to done=1 = 2*SETTLE*num_vectors + 1.

Decomposition:
- Shared package (or include file): ALU opcode constants (ADD=0, SUB=1, SLL=4, SRA=5), fault-mode encodings, FSM state encodings, LFSR tap constant.
- One natural sub-module: abl17_lfsr32, with load-seed and advance enable.
- FSM, vector mapping and counters stay in the top level.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles -> all outputs 0, busy=0, done=0. Then pulse start with num_vectors=0 -> done=1 on the next cycle, all counts 0.
- Golden ALU+checkers, fault_mode=0, num_vectors=8, SETTLE=1:
  - done exactly 17 cycles after start;
  - injected=8, detected=8, escaped=0, false_alarm=0;
  - flip1 high only in FAULT cycles;
  - ctrl_ALUopcode always 0 or 1.
- Stub flags tied 0, fault_mode=2, num_vectors=5 -> injected=5, escaped=5, detected=0; opcode in {4,5}; shift_flip is the only flip ever asserted.
- Stub asserting sra_has_error only in CLEAN cycles, fault_mode=3, num_vectors=6:
  - false_alarm=6;
  - effective modes sequence 0,1,2,0,1,2 (check which flip toggles per vector).
- Reset mid-campaign: deassert reset_n during the 3rd FAULT phase -> next cycle all flips 0, counters 0, busy=0. A new start reproduces the first vector: operandA=SEED.
- Saturation with CNT_W=4, num_vectors=15, golden ALU: detected=15 and stays at 15. A second campaign restarts counts at 0.
